// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared types and constants for the JK bank driver.
`default_nettype none

package jk_drv_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_IDLE   = 2'd3
    } state_t;

    localparam logic ENC_SR  = 1'b0;
    localparam logic ENC_TOG = 1'b1;

    // Counter only has to hold SETTLE_CYC-1; keep at least one bit.
    function automatic int settle_cnt_w(input int settle_cyc);
        return (settle_cyc < 2) ? 1 : $clog2(settle_cyc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_excite.sv
// jk_excite: combinational J/K excitation from target, shadow state and encoding select.
`default_nettype none

module jk_excite
    import jk_drv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] tgt,
    input  logic [W-1:0] shadow,
    input  logic         use_toggle,
    output logic [W-1:0] j_nxt,
    output logic [W-1:0] k_nxt
);

    logic [W-1:0] diff;

    assign diff = tgt ^ shadow;

    always_comb begin
        if (use_toggle == ENC_TOG) begin
            j_nxt = diff;
            k_nxt = diff;
        end else begin
            j_nxt = tgt & diff;
            k_nxt = ~tgt & diff;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: turns handshaked target words into one-cycle J/K pulses for a JK bank
// and checks the bank's Q feedback against a shadow copy after a settle delay.
`default_nettype none

module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [W-1:0] tgt_data,
    input  logic         use_toggle,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    input  logic [W-1:0] q_fb,
    output logic         busy,
    output logic         err,
    input  logic         err_clr
);

    localparam int              CNT_W    = settle_cnt_w(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     shadow;
    logic [W-1:0]     tgt_lat;
    logic [W-1:0]     j_exc;
    logic [W-1:0]     k_exc;
    logic [W-1:0]     j_nxt;
    logic [W-1:0]     k_nxt;
    logic [CNT_W-1:0] cnt;
    logic             init_pulsed;
    logic             check;

    jk_excite #(.W(W)) u_excite (
        .tgt        (tgt_data),
        .shadow     (shadow),
        .use_toggle (use_toggle),
        .j_nxt      (j_exc),
        .k_nxt      (k_exc)
    );

    assign tgt_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign check     = (state == ST_SETTLE) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // INIT spends two cycles: one launching the clear pulse, one while the bank captures it.
    always_comb begin
        state_nxt = state;
        j_nxt     = '0;
        k_nxt     = '0;
        case (state)
            ST_INIT: begin
                if (!init_pulsed) begin
                    k_nxt = '1;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_IDLE: begin
                if (tgt_valid) begin
                    state_nxt = ST_APPLY;
                    j_nxt     = j_exc;
                    k_nxt     = k_exc;
                end
            end
            ST_APPLY:  state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j           <= '0;
            k           <= '0;
            shadow      <= '0;
            tgt_lat     <= '0;
            cnt         <= '0;
            init_pulsed <= 1'b0;
            err         <= 1'b0;
        end else begin
            j <= j_nxt;
            k <= k_nxt;
            if (state == ST_INIT) begin
                init_pulsed <= 1'b1;
            end
            if ((state == ST_IDLE) && tgt_valid) begin
                tgt_lat <= tgt_data;
            end
            if (state == ST_APPLY) begin
                shadow <= tgt_lat;
            end
            if ((state_nxt == ST_SETTLE) && (state != ST_SETTLE)) begin
                cnt <= CNT_LAST;
            end else if ((state == ST_SETTLE) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            // A fresh mismatch wins over a simultaneous clear request.
            if (check && (q_fb != shadow)) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed self-checking bench with a behavioural JK bank on the outputs.
`default_nettype none

module tb_jk_bank_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_data;
    logic       use_toggle;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q_fb;
    logic       busy;
    logic       err;
    logic       err_clr;

    logic [3:0] bank;
    logic       stuck0 = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            case ({j[i], k[i]})
                2'b01:   bank[i] <= 1'b0;
                2'b10:   bank[i] <= 1'b1;
                2'b11:   bank[i] <= ~bank[i];
                default: bank[i] <= bank[i];
            endcase
        end
    end

    assign q_fb = stuck0 ? (bank & 4'b1110) : bank;

    jk_bank_driver #(.W(4), .SETTLE_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_data   (tgt_data),
        .use_toggle (use_toggle),
        .j          (j),
        .k          (k),
        .q_fb       (q_fb),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
    );

    // Leaves the bench at the negedge inside the APPLY cycle.
    task automatic send(input logic [3:0] w, input logic tog);
        int waited = 0;
        while (tgt_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (tgt_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ready=%b required 1", tgt_ready);
        end
        tgt_valid  = 1'b1;
        tgt_data   = w;
        use_toggle = tog;
        @(posedge clk);
        @(negedge clk);
        tgt_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (j !== 4'b0000)  begin errors++; $display("FAIL rst_j got %b required 0000", j); end
        checks++; if (k !== 4'b0000)  begin errors++; $display("FAIL rst_k got %b required 0000", k); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b required 0", tgt_ready); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL rst_busy got %b required 1", busy); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL rst_err got %b required 0", err); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (k !== 4'b1111 || j !== 4'b0000) begin errors++; $display("FAIL init_pulse j=%b k=%b required j=0000 k=1111", j, k); end
        @(negedge clk);
        checks++; if (k !== 4'b0000 || bank !== 4'b0000) begin errors++; $display("FAIL init_clear k=%b bank=%b required k=0000 bank=0000", k, bank); end
        @(negedge clk);
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL init_ready_early got %b required 0", tgt_ready); end
        @(negedge clk);
        checks++; if (tgt_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL init_ready ready=%b busy=%b required 1/0", tgt_ready, busy); end
        checks++; if (err !== 1'b0 || bank !== 4'b0000) begin errors++; $display("FAIL init_check err=%b bank=%b required 0/0000", err, bank); end
    endtask

    task automatic test_set_reset();
        send(4'b1010, 1'b0);
        checks++; if (j !== 4'b1010 || k !== 4'b0000) begin errors++; $display("FAIL sr1_jk j=%b k=%b required 1010/0000", j, k); end
        repeat (3) @(negedge clk);
        checks++; if (bank !== 4'b1010 || err !== 1'b0) begin errors++; $display("FAIL sr1_bank bank=%b err=%b required 1010/0", bank, err); end
        send(4'b0110, 1'b0);
        checks++; if (j !== 4'b0100 || k !== 4'b1000) begin errors++; $display("FAIL sr2_jk j=%b k=%b required 0100/1000", j, k); end
        repeat (3) @(negedge clk);
        checks++; if (bank !== 4'b0110) begin errors++; $display("FAIL sr2_bank got %b required 0110", bank); end
    endtask

    task automatic test_toggle();
        send(4'b0011, 1'b1);
        checks++; if (j !== 4'b0101 || k !== 4'b0101) begin errors++; $display("FAIL tog_jk j=%b k=%b required 0101/0101", j, k); end
        repeat (3) @(negedge clk);
        checks++; if (bank !== 4'b0011) begin errors++; $display("FAIL tog_bank got %b required 0011", bank); end
        send(4'b0011, 1'b1);
        checks++; if (j !== 4'b0000 || k !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL same_jk j=%b k=%b busy=%b required 0000/0000/1", j, k, busy); end
        repeat (2) @(negedge clk);
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("FAIL same_ready_early got %b required 0", tgt_ready); end
        @(negedge clk);
        checks++; if (tgt_ready !== 1'b1 || bank !== 4'b0011) begin errors++; $display("FAIL same_latency ready=%b bank=%b required 1/0011", tgt_ready, bank); end
    endtask

    task automatic test_mismatch();
        stuck0 = 1'b1;
        send(4'b0001, 1'b0);
        checks++; if (j !== 4'b0000 || k !== 4'b0010) begin errors++; $display("FAIL mm_jk j=%b k=%b required 0000/0010", j, k); end
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mm_err_early got %b required 0", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mm_err_set got %b required 1", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mm_err_sticky got %b required 1", err); end
        send(4'b0001, 1'b0);
        repeat (2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mm_set_priority got %b required 1", err); end
        stuck0  = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mm_clear got %b required 0", err); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [3];
        logic [3:0] exp_j [3];
        logic [3:0] exp_k [3];
        int         acc   [3];
        int         idx = 0;
        int         c   = 0;
        logic       was_ready;
        words = '{4'b1000, 4'b1100, 4'b1110};
        exp_j = '{4'b1000, 4'b0100, 4'b0010};
        exp_k = '{4'b0001, 4'b0000, 4'b0000};
        acc   = '{-1, -1, -1};
        use_toggle = 1'b0;
        tgt_valid  = 1'b1;
        while (idx < 3 && c < 20) begin
            tgt_data  = words[idx];
            was_ready = tgt_ready;
            @(posedge clk);
            @(negedge clk);
            if (was_ready === 1'b1) begin
                acc[idx] = c;
                checks++; if (j !== exp_j[idx] || k !== exp_k[idx]) begin errors++; $display("FAIL b2b_jk%0d j=%b k=%b required %b/%b", idx, j, k, exp_j[idx], exp_k[idx]); end
                idx++;
                if (idx == 3) tgt_valid = 1'b0;
            end
            c++;
        end
        tgt_valid = 1'b0;
        checks++; if (acc[0] != 0 || acc[1] != 4 || acc[2] != 8) begin errors++; $display("FAIL b2b_spacing got %0d,%0d,%0d required 0,4,8", acc[0], acc[1], acc[2]); end
        repeat (3) @(negedge clk);
        checks++; if (bank !== 4'b1110 || tgt_ready !== 1'b1) begin errors++; $display("FAIL b2b_bank bank=%b ready=%b required 1110/1", bank, tgt_ready); end
    endtask

    task automatic test_reset_abort();
        send(4'b0101, 1'b0);
        checks++; if (j !== 4'b0001 || k !== 4'b1010) begin errors++; $display("FAIL abort_jk j=%b k=%b required 0001/1010", j, k); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (j !== 4'b0000 || k !== 4'b0000 || tgt_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_async j=%b k=%b ready=%b busy=%b required 0000/0000/0/1", j, k, tgt_ready, busy); end
        @(negedge clk);
        checks++; if (bank !== 4'b1110) begin errors++; $display("FAIL abort_bank_held got %b required 1110", bank); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (k !== 4'b1111 || j !== 4'b0000) begin errors++; $display("FAIL abort_init j=%b k=%b required 0000/1111", j, k); end
        repeat (3) @(negedge clk);
        checks++; if (bank !== 4'b0000 || tgt_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL abort_done bank=%b ready=%b err=%b required 0000/1/0", bank, tgt_ready, err); end
    endtask

    initial begin
        rst_n      = 1'b0;
        tgt_valid  = 1'b0;
        tgt_data   = 4'b0000;
        use_toggle = 1'b0;
        err_clr    = 1'b0;
        test_reset();
        test_set_reset();
        test_toggle();
        test_mismatch();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
